audio_ctrl: RTL and testbench
=============================

AUDIO_CTRL -- requirements
Module: audio_ctrl

Interface
REQ-001 Parameter SONG_LEN, default 64: number of beats in the melody ROM, from 2 to 64.
REQ-002 Parameter SUB_PER_BEAT, default 16: tick pulses per beat, from 2 to 255.
REQ-003 Parameter VOL_MAX, default 5: highest volume level, at most 7.
REQ-004 Parameter VOL_RST, default 3: volume after reset, at most VOL_MAX.
REQ-005 Parameter LOOP, default 1: 1 restarts the song at its end; 0 stops at its end.
REQ-006 Ports, one per line:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- vol_up  in  1  one-cycle pulse from the debounced volume-up button.
- vol_down  in  1  one-cycle pulse from the debounced volume-down button.
- key_valid  in  1  one-cycle strobe; key_cmd is valid in that cycle.
- key_cmd  in  3  command code: 1 PLAY, 2 PAUSE, 3 STOP, 4 RESTART; all other codes are ignored.
- tick  in  1  one-cycle pulse from the beat clock, spaced at least 2 clk apart.
- rom_addr  out  6  melody ROM address; ROM read latency is 1 clk.
- rom_note  in  5  ROM data; 0 means rest.
- note  out  5  note index sent to Voice; 0 means silent.
- vol  out  3  volume level sent to Voice.
- playing  out  1  high in LOAD and PLAY.
- beat_pulse  out  1  one-cycle pulse at each beat boundary.
- song_end  out  1  one-cycle pulse when the song finishes with LOOP=0.

Function
REQ-007 States SHALL be IDLE, LOAD, PLAY and PAUSE, encoded in a 2-bit register; registers SHALL be cur_note (5 bits), sub (8 bits), addr (6 bits) and vol (3 bits).
REQ-008 Outputs SHALL be registered, except:
- rom_addr = addr;
- note = cur_note when in LOAD or PLAY, otherwise 0;
- playing is decoded from the state.
REQ-009 IDLE: PLAY or RESTART SHALL go to LOAD with addr=0 and sub=0; PAUSE and STOP SHALL be ignored.
REQ-010 LOAD SHALL last exactly 1 clk, then:
- cur_note <= rom_note;
- next state is PLAY;
- note still shows the previous cur_note during the LOAD cycle.
REQ-011 In LOAD and PLAY, each tick SHALL increment sub.
REQ-012 A tick with sub == SUB_PER_BEAT-1 SHALL be a beat boundary:
- sub <= 0;
- beat_pulse = 1 in the next cycle;
- if addr < SONG_LEN-1: addr <= addr+1, go to LOAD.
REQ-013 A beat boundary with addr == SONG_LEN-1 SHALL:
- with LOOP=1: set addr <= 0 and go to LOAD;
- with LOOP=0: set addr <= 0 and cur_note <= 0, pulse song_end for 1 clk, and go to IDLE.
REQ-014 PLAY with PAUSE SHALL go to PAUSE and hold addr, sub and cur_note.
REQ-015 PAUSE with PLAY SHALL return to PLAY; the resumed note equals cur_note from before the pause.
REQ-016 STOP in any state except IDLE SHALL go to IDLE with addr=0, sub=0 and cur_note=0.
REQ-017 RESTART in any state SHALL go to LOAD with addr=0 and sub=0.
REQ-018 When a command and a tick arrive in the same cycle, the command SHALL take priority and the tick SHALL be discarded; this includes a tick on a beat boundary.
REQ-019 These commands SHALL change nothing:
- PLAY while in PLAY or LOAD;
- PAUSE while in LOAD;
- PAUSE while in PAUSE.
REQ-020 Volume SHALL respond in every state:
- vol_up: vol+1, saturating at VOL_MAX;
- vol_down: vol-1, saturating at 0;
- vol_up and vol_down together: no change.
REQ-021 vol SHALL never leave the range 0..VOL_MAX, and sub SHALL never reach SUB_PER_BEAT.

Reset
REQ-022 rst=1 at a clk edge SHALL set, in any state and even mid-LOAD:
- state IDLE;
- addr, sub and cur_note to 0;
- vol to VOL_RST;
- beat_pulse and song_end to 0.
REQ-023 All inputs SHALL be ignored while rst=1.

Verification
Bench parameters: SONG_LEN=4, SUB_PER_BEAT=2, LOOP=0; ROM contents 5,7,9,0.
REQ-024 Sequencing and song end:
- stimulus: PLAY, then ticks every 4 clk;
- response: note goes 5,7,9,0 with beat_pulse at each boundary;
- response: song_end pulses once after the 8th tick, then IDLE with note=0 and rom_addr=0.
REQ-025 Pause and resume:
- stimulus: PAUSE while note=7 and sub=1, 10 ticks, then PLAY;
- response: note=0 while paused, addr holds at 1;
- response: after PLAY, note=7 and one more tick advances to 9.
REQ-026 Volume saturation:
- stimulus: after reset (vol=3), vol_up x4, then vol_down x7, then vol_up with vol_down together;
- response: vol goes 4,5,5,5, then down to 0 and holds at 0, then stays 0.
REQ-027 Command versus tick collision:
- stimulus: STOP in the same cycle as a boundary tick at addr=2;
- response: IDLE, addr=0, no beat_pulse, no song_end.
- stimulus: RESTART during PAUSE;
- response: LOAD, then note=5.
REQ-028 Reset mid-operation:
- stimulus: rst during LOAD at addr=3 with vol=1;
- response: next cycle IDLE, note=0, vol=3, playing=0.
- stimulus: repeat REQ-024 with LOOP=1;
- response: after 9, 0 comes 5 again with no song_end.

Source files
------------

// File: rtl/audio_ctrl.sv
// Melody sequencer: steps through a note ROM one beat at a time under play/pause/stop/restart
// commands and keeps a saturating volume level.
module audio_ctrl #(
    parameter int unsigned SONG_LEN     = 64,
    parameter int unsigned SUB_PER_BEAT = 16,
    parameter int unsigned VOL_MAX      = 5,
    parameter int unsigned VOL_RST      = 3,
    parameter int unsigned LOOP         = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vol_up,
    input  logic       vol_down,
    input  logic       key_valid,
    input  logic [2:0] key_cmd,
    input  logic       tick,
    output logic [5:0] rom_addr,
    input  logic [4:0] rom_note,
    output logic [4:0] note,
    output logic [2:0] vol,
    output logic       playing,
    output logic       beat_pulse,
    output logic       song_end
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        PLAY  = 2'd2,
        PAUSE = 2'd3
    } state_t;

    localparam logic [2:0] CMD_PLAY    = 3'd1;
    localparam logic [2:0] CMD_PAUSE   = 3'd2;
    localparam logic [2:0] CMD_STOP    = 3'd3;
    localparam logic [2:0] CMD_RESTART = 3'd4;

    localparam logic [5:0] LAST_ADDR = 6'(SONG_LEN - 1);
    localparam logic [7:0] LAST_SUB  = 8'(SUB_PER_BEAT - 1);
    localparam logic [2:0] VOL_TOP   = 3'(VOL_MAX);
    localparam logic [2:0] VOL_INIT  = 3'(VOL_RST);

    state_t     state;
    logic [4:0] cur_note;
    logic [7:0] sub;
    logic [5:0] addr;

    logic is_play, is_pause, is_stop, is_restart, any_cmd, adv;

    // Any recognised command swallows a coincident tick, even on a beat boundary.
    always_comb begin
        is_play    = key_valid && (key_cmd == CMD_PLAY);
        is_pause   = key_valid && (key_cmd == CMD_PAUSE);
        is_stop    = key_valid && (key_cmd == CMD_STOP);
        is_restart = key_valid && (key_cmd == CMD_RESTART);
        any_cmd    = is_play || is_pause || is_stop || is_restart;
        adv        = tick && !any_cmd;
    end

    assign rom_addr = addr;
    assign playing  = (state == LOAD) || (state == PLAY);
    assign note     = playing ? cur_note : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cur_note   <= '0;
            sub        <= '0;
            addr       <= '0;
            vol        <= VOL_INIT;
            beat_pulse <= 1'b0;
            song_end   <= 1'b0;
        end else begin
            beat_pulse <= 1'b0;
            song_end   <= 1'b0;

            if (vol_up && !vol_down && (vol != VOL_TOP)) begin
                vol <= vol + 3'd1;
            end else if (vol_down && !vol_up && (vol != '0)) begin
                vol <= vol - 3'd1;
            end

            if (is_restart) begin
                state <= LOAD;
                addr  <= '0;
                sub   <= '0;
            end else if (is_stop && (state != IDLE)) begin
                state    <= IDLE;
                addr     <= '0;
                sub      <= '0;
                cur_note <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (is_play) begin
                            state <= LOAD;
                            addr  <= '0;
                            sub   <= '0;
                        end
                    end
                    LOAD, PLAY: begin
                        if (state == LOAD) begin
                            cur_note <= rom_note;
                            state    <= PLAY;
                        end else if (is_pause) begin
                            state <= PAUSE;
                        end
                        // Beat handling is shared by LOAD and PLAY and overrides the LOAD->PLAY step.
                        if (adv) begin
                            if (sub == LAST_SUB) begin
                                sub        <= '0;
                                beat_pulse <= 1'b1;
                                if (addr < LAST_ADDR) begin
                                    addr  <= addr + 6'd1;
                                    state <= LOAD;
                                end else if (LOOP != 0) begin
                                    addr  <= '0;
                                    state <= LOAD;
                                end else begin
                                    addr     <= '0;
                                    cur_note <= '0;
                                    song_end <= 1'b1;
                                    state    <= IDLE;
                                end
                            end else begin
                                sub <= sub + 8'd1;
                            end
                        end
                    end
                    PAUSE: begin
                        if (is_play) begin
                            state <= PLAY;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_audio_ctrl.sv
// Scoreboard bench for audio_ctrl: one instance with LOOP=0 and one with LOOP=1, both on a
// four-entry ROM holding 5,7,9,0.
module tb_audio_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vol_up = 1'b0, vol_down = 1'b0;
    logic       key_valid = 1'b0, key_valid_b = 1'b0;
    logic [2:0] key_cmd = 3'd0, key_cmd_b = 3'd0;
    logic       tick = 1'b0, tick_b = 1'b0;

    logic [5:0] rom_addr, rom_addr_b;
    logic [4:0] rom_note, rom_note_b, note, note_b;
    logic [2:0] vol, vol_b;
    logic       playing, playing_b, beat_pulse, beat_pulse_b, song_end, song_end_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [4:0] rom_lookup(input logic [5:0] a);
        case (a[1:0])
            2'd0:    return 5'd5;
            2'd1:    return 5'd7;
            2'd2:    return 5'd9;
            default: return 5'd0;
        endcase
    endfunction

    assign rom_note   = rom_lookup(rom_addr);
    assign rom_note_b = rom_lookup(rom_addr_b);

    audio_ctrl #(.SONG_LEN(4), .SUB_PER_BEAT(2), .VOL_MAX(5), .VOL_RST(3), .LOOP(0)) dut (
        .clk(clk), .rst(rst), .vol_up(vol_up), .vol_down(vol_down),
        .key_valid(key_valid), .key_cmd(key_cmd), .tick(tick),
        .rom_addr(rom_addr), .rom_note(rom_note), .note(note), .vol(vol),
        .playing(playing), .beat_pulse(beat_pulse), .song_end(song_end)
    );

    audio_ctrl #(.SONG_LEN(4), .SUB_PER_BEAT(2), .VOL_MAX(5), .VOL_RST(3), .LOOP(1)) dut_b (
        .clk(clk), .rst(rst), .vol_up(1'b0), .vol_down(1'b0),
        .key_valid(key_valid_b), .key_cmd(key_cmd_b), .tick(tick_b),
        .rom_addr(rom_addr_b), .rom_note(rom_note_b), .note(note_b), .vol(vol_b),
        .playing(playing_b), .beat_pulse(beat_pulse_b), .song_end(song_end_b)
    );

    // Expected output events, pushed by the stimulus and consumed by the monitor.
    logic [4:0]  note_q[$];
    logic [2:0]  vol_q[$];
    logic [13:0] pulse_q[$];
    logic [4:0]  note_b_q[$];

    logic        mon_on = 1'b0;
    logic [4:0]  prev_note = 5'd0, prev_note_b = 5'd0;
    logic [2:0]  prev_vol = 3'd3;
    int          song_end_b_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name, input int act);
        total++;
        bad++;
        $display("FAIL %s: unexpected output 0x%0h with nothing expected at %0t", name, act, $time);
    endtask

    function automatic logic [13:0] pt(input logic bp, input logic se, input logic [5:0] a,
                                       input logic [4:0] n, input logic pl);
        return {bp, se, a, n, pl};
    endfunction

    always @(negedge clk) begin
        if (mon_on) begin
            if (note != prev_note) begin
                if (note_q.size() == 0) unexpected("note_change", int'(note));
                else check("note_change", int'(note), int'(note_q.pop_front()));
                prev_note = note;
            end
            if (vol != prev_vol) begin
                if (vol_q.size() == 0) unexpected("vol_change", int'(vol));
                else check("vol_change", int'(vol), int'(vol_q.pop_front()));
                prev_vol = vol;
            end
            if (beat_pulse || song_end) begin
                if (pulse_q.size() == 0)
                    unexpected("pulse", int'(pt(beat_pulse, song_end, rom_addr, note, playing)));
                else
                    check("pulse", int'(pt(beat_pulse, song_end, rom_addr, note, playing)),
                          int'(pulse_q.pop_front()));
            end
            if (note_b != prev_note_b) begin
                if (note_b_q.size() == 0) unexpected("loop_note_change", int'(note_b));
                else check("loop_note_change", int'(note_b), int'(note_b_q.pop_front()));
                prev_note_b = note_b;
            end
            if (song_end_b) song_end_b_cnt++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] c);
        key_valid = 1'b1;
        key_cmd   = c;
        cyc(1);
        key_valid = 1'b0;
        key_cmd   = 3'd0;
    endtask

    task automatic send_b(input logic [2:0] c);
        key_valid_b = 1'b1;
        key_cmd_b   = c;
        cyc(1);
        key_valid_b = 1'b0;
        key_cmd_b   = 3'd0;
    endtask

    task automatic tk();
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
    endtask

    task automatic tk4();
        tk();
        cyc(3);
    endtask

    task automatic tk4_b();
        tick_b = 1'b1;
        cyc(1);
        tick_b = 1'b0;
        cyc(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(2);
        rst = 1'b0;
        @(negedge clk);
        check("rst_note", int'(note), 0);
        check("rst_vol", int'(vol), 3);
        check("rst_playing", int'(playing), 0);
        check("rst_rom_addr", int'(rom_addr), 0);
        check("rst_beat_pulse", int'(beat_pulse), 0);
        check("rst_song_end", int'(song_end), 0);
        mon_on = 1'b1;
        cyc(1);

        // Volume saturation at both ends, and up+down together holding.
        vol_q.push_back(3'd4);
        vol_q.push_back(3'd5);
        for (int i = 0; i < 4; i++) begin
            vol_up = 1'b1; cyc(1); vol_up = 1'b0; cyc(1);
        end
        for (int i = 4; i >= 0; i--) vol_q.push_back(3'(i));
        for (int i = 0; i < 7; i++) begin
            vol_down = 1'b1; cyc(1); vol_down = 1'b0; cyc(1);
        end
        vol_up = 1'b1; vol_down = 1'b1; cyc(1); vol_up = 1'b0; vol_down = 1'b0; cyc(1);
        @(negedge clk);
        check("vol_floor_hold", int'(vol), 0);
        vol_q.push_back(3'd1);
        vol_up = 1'b1; cyc(1); vol_up = 1'b0; cyc(1);

        // Full song with LOOP=0.
        note_q.push_back(5'd5);
        send(3'd1);
        @(negedge clk);
        check("load_playing", int'(playing), 1);
        check("load_prev_note", int'(note), 0);
        for (int i = 0; i < 8; i++) begin
            if (i == 1) begin pulse_q.push_back(pt(1, 0, 1, 5, 1)); note_q.push_back(5'd7); end
            if (i == 3) begin pulse_q.push_back(pt(1, 0, 2, 7, 1)); note_q.push_back(5'd9); end
            if (i == 5) begin pulse_q.push_back(pt(1, 0, 3, 9, 1)); note_q.push_back(5'd0); end
            if (i == 7) pulse_q.push_back(pt(1, 1, 0, 0, 0));
            tk4();
        end
        @(negedge clk);
        check("end_rom_addr", int'(rom_addr), 0);
        check("end_playing", int'(playing), 0);
        check("end_note", int'(note), 0);

        // Pause at note 7 / sub 1, ticks ignored while paused, then resume.
        note_q.push_back(5'd5);
        send(3'd1);
        tk4();
        pulse_q.push_back(pt(1, 0, 1, 5, 1)); note_q.push_back(5'd7);
        tk4();
        tk4();
        note_q.push_back(5'd0);
        send(3'd2);
        for (int i = 0; i < 10; i++) tk4();
        @(negedge clk);
        check("pause_rom_addr", int'(rom_addr), 1);
        check("pause_playing", int'(playing), 0);
        note_q.push_back(5'd7);
        send(3'd1);
        cyc(1);
        @(negedge clk);
        check("resume_note", int'(note), 7);
        pulse_q.push_back(pt(1, 0, 2, 7, 1)); note_q.push_back(5'd9);
        tk4();
        tk4();

        // STOP coinciding with the boundary tick at addr 2: no beat, no song end.
        note_q.push_back(5'd0);
        key_valid = 1'b1; key_cmd = 3'd3; tick = 1'b1;
        cyc(1);
        key_valid = 1'b0; key_cmd = 3'd0; tick = 1'b0;
        cyc(3);
        @(negedge clk);
        check("stop_rom_addr", int'(rom_addr), 0);
        check("stop_playing", int'(playing), 0);

        // RESTART from PAUSE: LOAD still shows the old note, then note 5.
        note_q.push_back(5'd5);
        send(3'd1);
        tk4();
        pulse_q.push_back(pt(1, 0, 1, 5, 1)); note_q.push_back(5'd7);
        tk4();
        note_q.push_back(5'd0);
        send(3'd2);
        cyc(2);
        note_q.push_back(5'd7); note_q.push_back(5'd5);
        send(3'd4);
        @(negedge clk);
        check("restart_load_playing", int'(playing), 1);
        check("restart_rom_addr", int'(rom_addr), 0);
        check("restart_load_note", int'(note), 7);
        cyc(2);
        @(negedge clk);
        check("restart_note", int'(note), 5);
        note_q.push_back(5'd0);
        send(3'd3);
        cyc(2);

        // Reset during LOAD at addr 3 with vol 1.
        note_q.push_back(5'd5);
        send(3'd1);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin pulse_q.push_back(pt(1, 0, 1, 5, 1)); note_q.push_back(5'd7); end
            if (i == 3) begin pulse_q.push_back(pt(1, 0, 2, 7, 1)); note_q.push_back(5'd9); end
            tk4();
        end
        pulse_q.push_back(pt(1, 0, 3, 9, 1));
        tk();
        @(negedge clk);
        check("pre_rst_rom_addr", int'(rom_addr), 3);
        check("pre_rst_vol", int'(vol), 1);
        note_q.push_back(5'd0);
        vol_q.push_back(3'd3);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_playing", int'(playing), 0);
        check("mid_rst_note", int'(note), 0);
        check("mid_rst_vol", int'(vol), 3);
        check("mid_rst_rom_addr", int'(rom_addr), 0);
        cyc(2);

        // LOOP=1 instance wraps back to note 5 with no song end.
        note_b_q.push_back(5'd5);
        send_b(3'd1);
        for (int i = 0; i < 10; i++) begin
            if (i == 1) note_b_q.push_back(5'd7);
            if (i == 3) note_b_q.push_back(5'd9);
            if (i == 5) note_b_q.push_back(5'd0);
            if (i == 7) note_b_q.push_back(5'd5);
            if (i == 9) note_b_q.push_back(5'd7);
            tk4_b();
        end
        cyc(4);
        @(negedge clk);
        check("loop_playing", int'(playing_b), 1);
        check("loop_song_end_count", song_end_b_cnt, 0);

        check("note_q_left", note_q.size(), 0);
        check("vol_q_left", vol_q.size(), 0);
        check("pulse_q_left", pulse_q.size(), 0);
        check("loop_note_q_left", note_b_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
